// File: rtl/lsu_wb_master_if.sv
// Load/store request, response and Wishbone classic signals for lsu_wb_master.
// master is the block's own view; slave is the view of the core/uncore side.
interface lsu_wb_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] adr_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;

  modport master (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  dat_i, ack_i, err_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output cyc_o, stb_o, adr_o, we_o, sel_o, dat_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output dat_i, ack_i, err_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  cyc_o, stb_o, adr_o, we_o, sel_o, dat_o
  );
endinterface

// File: rtl/lsu_wb_master.sv
// Single-beat Wishbone classic initiator for the LSU: one access outstanding,
// byte-lane steering on writes, align/extend on reads, misalign/error/timeout reporting.
module lsu_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  lsu_wb_master_if.master bus
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam bit         TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = (off != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_sel(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_sel = 4'b0001 << off;
      2'd1:    byte_sel = off[1] ? 4'b1100 : 4'b0011;
      default: byte_sel = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'd0:    lane_replicate = {4{wdata[7:0]}};
      2'd1:    lane_replicate = {2{wdata[15:0]}};
      default: lane_replicate = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] data, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] sh;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    load_extend = {{24{~uns & sh[7]}}, sh[7:0]};
      2'd1:    load_extend = {{16{~uns & sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic req_ready;
  logic timeout_hit;

  assign req_ready   = (state_q == IDLE) && !rst_i;
  assign timeout_hit = TO_EN && (({1'b0, cnt_q} + 9'd1) == TO_LIM);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    we_d        = we_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i && req_ready) begin
          if (is_misaligned(bus.req_size_i, bus.req_addr_i[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            adr_d   = {bus.req_addr_i[31:2], 2'b00};
            we_d    = bus.req_we_i;
            sel_d   = byte_sel(bus.req_size_i, bus.req_addr_i[1:0]);
            dat_d   = lane_replicate(bus.req_size_i, bus.req_wdata_i);
            off_d   = bus.req_addr_i[1:0];
            size_d  = bus.req_size_i;
            uns_d   = bus.req_unsigned_i;
            cnt_d   = 8'd0;
            cyc_d   = 1'b1;
            state_d = BUS;
          end
        end
      end
      default: begin
        // err beats ack; the timeout only fires on a cycle with neither.
        if (bus.err_i || (!bus.ack_i && timeout_hit)) begin
          cyc_d       = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (bus.ack_i) begin
          cyc_d       = 1'b0;
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : load_extend(bus.dat_i, off_q, size_q, uns_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      adr_q       <= 32'h0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      dat_q       <= 32'h0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      cnt_q       <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.cyc_o       = cyc_q;
  assign bus.stb_o       = cyc_q;
  assign bus.adr_o       = adr_q;
  assign bus.we_o        = we_q;
  assign bus.sel_o       = sel_q;
  assign bus.dat_o       = dat_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// Self-checking bench for lsu_wb_master: directed vector table, reset/idle
// sequences, and randomized accesses checked against an arithmetic model.
module tb_lsu_wb_master;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lsu_wb_master_if bus ();

  lsu_wb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          waits;
    logic        serr;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    int          e_cyc;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: expectations derived arithmetically from the access rules.
  function automatic vec_t model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata,
                                 input logic [31:0] sdata, input int waits, input logic serr);
    vec_t v;
    int off;
    logic mis;
    logic [31:0] val;
    off = int'(addr % 4);
    v.we = we; v.addr = addr; v.size = size; v.uns = uns;
    v.wdata = wdata; v.sdata = sdata; v.waits = waits; v.serr = serr;
    mis = (size == 3) || (size == 1 && off % 2 == 1) || (size == 2 && off != 0);
    v.e_adr = addr - 32'(off);
    if (size == 0)      v.e_sel = 4'(1 << off);
    else if (size == 1) v.e_sel = (off >= 2) ? 4'd12 : 4'd3;
    else                v.e_sel = 4'd15;
    if (size == 0)      v.e_dat = (wdata % 256) * 32'h01010101;
    else if (size == 1) v.e_dat = (wdata % 65536) * 32'h00010001;
    else                v.e_dat = wdata;
    v.e_cyc = mis ? 0 : ((waits < TO) ? waits + 1 : TO);
    v.e_err = mis || serr || (waits >= TO);
    val = sdata >> (8 * off);
    if (size == 0) begin
      val = val % 256;
      if (!uns && val >= 128) val = val + 32'hFFFFFF00;
    end else if (size == 1) begin
      val = val % 65536;
      if (!uns && val >= 32768) val = val + 32'hFFFF0000;
    end
    v.e_rdata = (v.e_err || we) ? 32'h0 : val;
    return v;
  endfunction

  task automatic txn(input vec_t v, input string tag);
    int  cyc_cnt;
    bit  done;
    @(negedge clk);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = v.we; bus.req_addr_i = v.addr; bus.req_size_i = v.size;
    bus.req_unsigned_i = v.uns; bus.req_wdata_i = v.wdata;
    bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.dat_i = 32'h0;
    chk({tag, ".ready"}, 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    cyc_cnt = 0;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (bus.rsp_valid_o) begin
        done = 1'b1;
      end else begin
        if (bus.cyc_o) begin
          cyc_cnt++;
          if (cyc_cnt == 1) begin
            chk({tag, ".adr"}, bus.adr_o, v.e_adr);
            chk({tag, ".sel"}, 32'(bus.sel_o), 32'(v.e_sel));
            chk({tag, ".dat"}, bus.dat_o, v.e_dat);
            chk({tag, ".we"},  32'(bus.we_o), 32'(v.we));
            chk({tag, ".stb"}, 32'(bus.stb_o), 32'd1);
          end
          if (k == v.waits) begin
            bus.ack_i = 1'b1;
            bus.err_i = v.serr;
            bus.dat_i = v.sdata;
          end
        end
        @(posedge clk); #1;
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = 32'h0;
      end
    end
    chk({tag, ".rsp_seen"}, 32'(done), 32'd1);
    chk({tag, ".cyc_cycles"}, 32'(cyc_cnt), 32'(v.e_cyc));
    chk({tag, ".err"}, 32'(bus.rsp_err_o), 32'(v.e_err));
    chk({tag, ".rdata"}, bus.rsp_rdata_o, v.e_rdata);
    chk({tag, ".cyc_low_at_rsp"}, 32'(bus.cyc_o), 32'd0);
    chk({tag, ".ready_at_rsp"}, 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #1;
    chk({tag, ".rsp_one_cycle"}, 32'(bus.rsp_valid_o), 32'd0);
  endtask

  initial begin
    int hits;
    vec_t v;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h0;
    bus.req_size_i = 2'd0; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'h0;
    bus.dat_i = 32'h0; bus.ack_i = 1'b0; bus.err_i = 1'b0;

    //          we    addr          sz  uns wdata         sdata         wt   serr adr           sel      dat           cyc err   rdata
    tbl[0] = '{1'b0, 32'h20000c08, 2, 0, 32'h0,        32'h12345678, 0,   0, 32'h20000c08, 4'b1111, 32'h0,        1, 1'b0, 32'h12345678};
    tbl[1] = '{1'b1, 32'h20000c01, 0, 0, 32'h000000A5, 32'h0,        0,   0, 32'h20000c00, 4'b0010, 32'hA5A5A5A5, 1, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h20000c02, 1, 0, 32'h0,        32'h80010000, 0,   0, 32'h20000c00, 4'b1100, 32'h0,        1, 1'b0, 32'hFFFF8001};
    tbl[3] = '{1'b0, 32'h20000c02, 1, 1, 32'h0,        32'h80010000, 0,   0, 32'h20000c00, 4'b1100, 32'h0,        1, 1'b0, 32'h00008001};
    tbl[4] = '{1'b0, 32'h20000c03, 0, 0, 32'h0,        32'h7F000000, 0,   0, 32'h20000c00, 4'b1000, 32'h0,        1, 1'b0, 32'h0000007F};
    tbl[5] = '{1'b0, 32'h20000c02, 2, 0, 32'h0,        32'h11111111, 0,   0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'h0};
    tbl[6] = '{1'b1, 32'h20000c00, 3, 0, 32'h55555555, 32'h0,        0,   0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'h0};
    tbl[7] = '{1'b0, 32'h20000c04, 2, 0, 32'h0,        32'hDEADBEEF, 0,   1, 32'h20000c04, 4'b1111, 32'h0,        1, 1'b1, 32'h0};
    tbl[8] = '{1'b1, 32'h20000c06, 1, 0, 32'h1234BEEF, 32'h0,        3,   0, 32'h20000c04, 4'b1100, 32'hBEEFBEEF, 4, 1'b0, 32'h0};
    tbl[9] = '{1'b0, 32'h20000c10, 2, 0, 32'h0,        32'h0,        255, 0, 32'h20000c10, 4'b1111, 32'h0,        4, 1'b1, 32'h0};

    // Reset state
    #1;
    chk("rst.ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst.cyc", 32'(bus.cyc_o), 32'd0);
    chk("rst.stb", 32'(bus.stb_o), 32'd0);
    chk("rst.rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst.rsp_err", 32'(bus.rsp_err_o), 32'd0);
    chk("rst.rdata", bus.rsp_rdata_o, 32'h0);
    chk("rst.adr", bus.adr_o, 32'h0);
    chk("rst.sel", 32'(bus.sel_o), 32'h0);
    chk("rst.dat", bus.dat_o, 32'h0);
    chk("rst.we", 32'(bus.we_o), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst.ready_after_release", 32'(bus.req_ready_o), 32'd1);

    // ack/err while idle must not produce anything
    @(negedge clk);
    bus.ack_i = 1'b1; bus.err_i = 1'b1; bus.dat_i = 32'hFFFFFFFF;
    hits = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.rsp_valid_o || bus.cyc_o) hits++;
    end
    chk("idle.ack_ignored", 32'(hits), 32'd0);
    bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.dat_i = 32'h0;

    for (int i = 0; i < 10; i++) txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while the bus cycle is open
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h20000c20;
    bus.req_size_i = 2'd2; bus.req_unsigned_i = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    chk("rstmid.cyc_open", 32'(bus.cyc_o), 32'd1);
    @(posedge clk); #2;
    rst_i = 1'b1;
    #1;
    chk("rstmid.cyc_async", 32'(bus.cyc_o), 32'd0);
    chk("rstmid.stb_async", 32'(bus.stb_o), 32'd0);
    chk("rstmid.ready", 32'(bus.req_ready_o), 32'd0);
    hits = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.rsp_valid_o) hits++;
    end
    @(negedge clk);
    rst_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rsp_valid_o || bus.cyc_o) hits++;
    end
    chk("rstmid.no_rsp", 32'(hits), 32'd0);
    txn(tbl[0], "post_rst");

    // Randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      v = model(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0));
      txn(v, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
